// File: rtl/window_mc_pkg.sv
// Shared types and fixed-point helpers for the multi-channel window block.
// The helpers are width-generic so FIR/FFT scaling stages can reuse them.
package window_mc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Divide by 2^sh with round-half-to-even; sh must be >= 1.
    function automatic logic signed [63:0] convergent_round(input logic signed [63:0] p,
                                                             input int sh);
        logic signed [63:0] q;
        logic [63:0]        frac;
        logic [63:0]        half;
        q    = p >>> sh;
        frac = $unsigned(p) & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if ((frac > half) || ((frac == half) && q[0])) begin
            q = q + 64'sd1;
        end
        return q;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/window_mc_coeff_ram.sv
// Simple dual-port coefficient store: synchronous write, registered read with enable.
// Contents are not reset so coefficients survive a datapath reset.
module window_mc_coeff_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/window_mc.sv
// Multi-channel, multi-bank window: one coefficient fetch per sample index shared by
// all lanes, 2-stage pipeline (coefficient read, multiply + convergent round).
module window_mc
    import window_mc_pkg::*;
#(
    parameter int N           = 1024,
    parameter int DATA_WIDTH  = 14,
    parameter int COEFF_WIDTH = 16,
    parameter int NCHAN       = 2,
    parameter int NWIN        = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clk_en_i,
    input  logic                          start_i,
    input  logic [$clog2(NWIN+1)-1:0]     win_sel_i,
    input  logic                          di_valid_i,
    input  logic [NCHAN*DATA_WIDTH-1:0]   di_i,
    output logic                          dvalid_o,
    output logic                          dlast_o,
    output logic [NCHAN*DATA_WIDTH-1:0]   dout_o,
    output logic                          busy_o,
    input  logic                          coef_we_i,
    input  logic [$clog2(NWIN+1)-1:0]     coef_bank_i,
    input  logic [$clog2(N)-1:0]          coef_addr_i,
    input  logic [COEFF_WIDTH-1:0]        coef_data_i,
    output logic                          coef_err_o
);

    localparam int BW  = $clog2(NWIN + 1);
    localparam int AW  = $clog2(N);
    localparam int RAW = $clog2(NWIN * N);
    localparam int DW  = DATA_WIDTH;
    localparam int CW  = COEFF_WIDTH;
    localparam int PW  = DW + CW + 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   ctr_q, ctr_d;
    logic [BW-1:0]   bank_q, bank_d;

    logic [BW-1:0]   sel_eff;
    logic            run;
    logic            frame_acc;
    logic            accept;
    logic [AW-1:0]   idx;
    logic [BW-1:0]   rd_bank;
    logic            rd_rect;

    always_comb begin
        sel_eff   = (win_sel_i > BW'(NWIN)) ? BW'(NWIN) : win_sel_i;
        run       = (state_q == ST_RUN);
        frame_acc = clk_en_i & ~run & start_i & di_valid_i;
        accept    = frame_acc | (clk_en_i & run & di_valid_i);
        idx       = run ? ctr_q : '0;
        rd_bank   = run ? bank_q : sel_eff;
        rd_rect   = (rd_bank == BW'(NWIN));
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        bank_d  = bank_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_acc) begin
                    state_d = ST_RUN;
                    ctr_d   = AW'(1);
                    bank_d  = sel_eff;
                end
            end
            ST_RUN: begin
                if (clk_en_i && di_valid_i) begin
                    if (ctr_q == AW'(N - 1)) begin
                        state_d = ST_IDLE;
                        ctr_d   = '0;
                    end else begin
                        ctr_d = ctr_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            bank_q  <= bank_d;
        end
    end

    // The bank about to be latched is protected on the accepting cycle too.
    logic            wr_reject;
    logic            wr_en;
    logic            coef_err_d, coef_err_q;
    logic [RAW-1:0]  waddr;
    logic [RAW-1:0]  raddr;
    logic            re;
    logic [CW-1:0]   coef_q;

    always_comb begin
        wr_reject  = (coef_bank_i >= BW'(NWIN))
                   | (run & (coef_bank_i == bank_q))
                   | (frame_acc & (coef_bank_i == sel_eff));
        wr_en      = coef_we_i & ~wr_reject;
        coef_err_d = coef_we_i & wr_reject;
        waddr      = RAW'(int'(coef_bank_i) * N + int'(coef_addr_i));
        raddr      = rd_rect ? '0 : RAW'(int'(rd_bank) * N + int'(idx));
        re         = accept & ~rd_rect;
    end

    window_mc_coeff_ram #(
        .DEPTH (NWIN * N),
        .WIDTH (CW),
        .AW    (RAW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (waddr),
        .wdata_i (coef_data_i),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (coef_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= coef_err_d;
        end
    end

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic                    s1_rect_q;
    logic [NCHAN*DW-1:0]     s1_di_q;

    always_comb begin
        s1_valid_d = accept;
        s1_last_d  = accept & (idx == AW'(N - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_rect_q  <= 1'b0;
            s1_di_q    <= '0;
        end else if (clk_en_i) begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_rect_q  <= rd_rect;
            s1_di_q    <= di_i;
        end
    end

    logic [NCHAN*DW-1:0] dout_d;

    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_lane
        logic signed [DW-1:0] a;
        logic signed [PW-1:0] prod;
        logic signed [63:0]   rnd;
        logic signed [63:0]   sat;
        logic [DW-1:0]        lane;

        // Coefficient is zero-extended so 0xFFFF stays positive.
        always_comb begin
            a    = s1_di_q[ch*DW +: DW];
            prod = PW'(a) * $signed({{(PW-CW){1'b0}}, coef_q});
            rnd  = convergent_round(64'(prod), CW);
            sat  = saturate(rnd, DW);
            lane = s1_rect_q ? a : DW'(sat);
        end

        assign dout_d[ch*DW +: DW] = lane;
    end

    logic                dvalid_q;
    logic                dlast_q;
    logic [NCHAN*DW-1:0] dout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            dout_q   <= '0;
        end else if (clk_en_i) begin
            dvalid_q <= s1_valid_q;
            dlast_q  <= s1_last_q;
            dout_q   <= dout_d;
        end
    end

    assign dvalid_o   = dvalid_q;
    assign dlast_o    = dlast_q;
    assign dout_o     = dout_q;
    assign busy_o     = run;
    assign coef_err_o = coef_err_q;

endmodule

// File: tb/tb_window_mc.sv
// Directed bench for window_mc: coefficient loading, windowed frames, rounding,
// rectangular bypass, write rejection, stalls and mid-frame reset.
module tb_window_mc;

    localparam int N    = 1024;
    localparam int DW   = 14;
    localparam int CW   = 16;
    localparam int NWIN = 2;
    localparam int BW   = 2;
    localparam int AW   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              start;
    logic [BW-1:0]     win_sel;
    logic              di_valid;
    logic [2*DW-1:0]   di;
    logic              dvalid;
    logic              dlast;
    logic [2*DW-1:0]   dout;
    logic              busy;
    logic              coef_we;
    logic [BW-1:0]     coef_bank;
    logic [AW-1:0]     coef_addr;
    logic [CW-1:0]     coef_data;
    logic              coef_err;

    always #5 clk = ~clk;

    window_mc #(
        .N           (N),
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .NCHAN       (2),
        .NWIN        (NWIN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_en_i    (clk_en),
        .start_i     (start),
        .win_sel_i   (win_sel),
        .di_valid_i  (di_valid),
        .di_i        (di),
        .dvalid_o    (dvalid),
        .dlast_o     (dlast),
        .dout_o      (dout),
        .busy_o      (busy),
        .coef_we_i   (coef_we),
        .coef_bank_i (coef_bank),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .coef_err_o  (coef_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected-output pipeline: p1 = sample accepted last clk_en edge, p2 = on dout.
    logic          m_run = 1'b0;
    int            m_idx = 0;
    logic          p1v = 1'b0, p1l = 1'b0, p2v = 1'b0, p2l = 1'b0;
    logic [DW-1:0] p1e0 = '0, p1e1 = '0, p2e0 = '0, p2e1 = '0;
    int            out_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cw(input int bank, input int addr, input int data);
        coef_we   = 1'b1;
        coef_bank = BW'(bank);
        coef_addr = AW'(addr);
        coef_data = CW'(data);
    endtask

    task automatic step(input bit st, input bit v, input bit en,
                        input int d0, input int d1, input int e0, input int e1,
                        input bit exp_err);
        logic acc;
        logic lst;
        start    = st;
        di_valid = v;
        clk_en   = en;
        di       = {DW'(d1), DW'(d0)};
        @(posedge clk);
        if (en) begin
            acc = v && (m_run || st);
            lst = 1'b0;
            if (acc) begin
                if (!m_run) m_idx = 0;
                lst   = (m_idx == N - 1);
                m_run = !lst;
                m_idx = lst ? 0 : m_idx + 1;
            end
            p2v  = p1v;  p2l  = p1l;  p2e0 = p1e0; p2e1 = p1e1;
            p1v  = acc;  p1l  = lst;  p1e0 = DW'(e0); p1e1 = DW'(e1);
            if (p2v) out_cnt++;
        end
        #1;
        check("dvalid", dvalid, p2v);
        check("dlast", dlast, p2l);
        if (p2v) begin
            check("dout_ch0", dout[DW-1:0], p2e0);
            check("dout_ch1", dout[2*DW-1:DW], p2e1);
        end
        check("busy", busy, m_run);
        check("coef_err", coef_err, exp_err);
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_run    = 1'b0;
        m_idx    = 0;
        p1v = 1'b0; p1l = 1'b0; p2v = 1'b0; p2l = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int j;
        int e0, e1, d0, d1;
        bit err;
        bit en, v;

        rst = 1'b0; clk_en = 1'b0; start = 1'b0; win_sel = '0; di_valid = 1'b0;
        di = '0; coef_we = 1'b0; coef_bank = '0; coef_addr = '0; coef_data = '0;
        #1;
        do_reset();
        check("rst_dvalid", dvalid, 1'b0);
        check("rst_dlast", dlast, 1'b0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_coef_err", coef_err, 1'b0);

        // Load bank0 with 0.5 and bank1 with 0xFFFF (clk_en low: writes still land).
        for (int i = 0; i < N; i++) begin
            cw(0, i, 16'h8000);
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < N; i++) begin
            cw(1, i, 16'hFFFF);
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Frame A: bank0, +1000 -> 500; writes to the active bank are rejected.
        win_sel = 2'd0;
        out_cnt = 0;
        for (int i = 0; i < N; i++) begin
            err = 1'b0;
            if (i == 0)  begin cw(0, 3, 0);          err = 1'b1; end
            if (i == 10) begin cw(0, 1000, 0);       err = 1'b1; end
            if (i == 11) begin cw(1, 5, 16'h4000);   err = 1'b0; end
            if (i == 12) begin cw(2, 0, 0);          err = 1'b1; end
            if (i == 13) begin cw(3, 0, 0);          err = 1'b1; end
            if (i == 20) win_sel = 2'd1;
            step(i == 0, 1, 1, 1000, 1000, 500, 500, err);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
        check("frameA_count", out_cnt, N);

        // Frame B: rounding ties, di_valid gaps, clk_en stalls, start during RUN.
        win_sel = 2'd0;
        out_cnt = 0;
        k = 0;
        j = 0;
        while (k < N && j < 4000) begin
            en = (j % 7 != 3);
            v  = (j % 5 != 2);
            d0 = 1000; d1 = 1000; e0 = 500; e1 = 500;
            if (k == 0) begin d0 = 3;    d1 = 5;     e0 = 2;    e1 = 2;     end
            if (k == 1) begin d0 = -3;   d1 = -5;    e0 = -2;   e1 = -2;    end
            if (k == 2) begin d0 = 7;    d1 = -7;    e0 = 4;    e1 = -4;    end
            if (k == 3) begin d0 = 8191; d1 = -8192; e0 = 4096; e1 = -4096; end
            if (!(en && v)) begin d0 = 777; d1 = -777; end
            step((j == 0) || (j == 150), v, en, d0, d1, e0, e1, 0);
            if (en && v) k++;
            j++;
        end
        check("frameB_len", k, N);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
        check("frameB_count", out_cnt, N);

        // Frame C: rectangular bank, full-scale inputs pass through unchanged.
        win_sel = 2'd2;
        out_cnt = 0;
        for (int i = 0; i < N; i++) begin
            d0 = (i % 2 == 0) ? -8192 : 8191;
            d1 = (i % 2 == 0) ? 8191 : -8192;
            step(i == 0, 1, 1, d0, d1, d0, d1, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
        check("frameC_count", out_cnt, N);

        // Frame D: out-of-range win_sel runs rectangular; reset at index 500.
        win_sel = 2'd3;
        for (int i = 0; i < 500; i++) begin
            step(i == 0, 1, 1, 123 + i, -456, 123 + i, -456, 0);
        end
        di_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);

        // Frame E: bank1 (0xFFFF -> x1, index 5 rewritten to 0.25 during frame A).
        win_sel = 2'd1;
        out_cnt = 0;
        for (int i = 0; i < N; i++) begin
            e0 = (i == 5) ? 250 : 1000;
            step(i == 0, 1, 1, 1000, 1000, e0, e0, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
        check("frameE_count", out_cnt, N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
